// File: rtl/apb_master_pkg.sv
// Shared types for the APB3 requester: FSM state encoding, command record and default widths.
package apb_master_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_if.sv
// Command/response port plus APB3 bus of the requester, grouped as one interface.
interface apb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, psel, penable, pwrite, pwdata
    );

endinterface

// File: rtl/apb_master_cmd_fifo.sv
// Synchronous command FIFO with show-ahead read port; pointers carry a wrap bit for full/empty.
module apb_cmd_fifo
    import apb_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  apb_cmd_t i_data,
    input  logic     i_pop,
    output apb_cmd_t o_data,
    output logic     o_full,
    output logic     o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    apb_cmd_t         r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB3 requester: buffered valid/ready commands issued as SETUP/ACCESS transfers, one-cycle response pulse.
// Optional macro APB_MASTER_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYC wait cycles.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    apb_master_if.master bus
);
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;

    logic [1:0]        r_state;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    apb_cmd_t          w_push_cmd;
    apb_cmd_t          w_pop_cmd;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_done;
    logic              w_abort;

    assign bus.cmd_ready = !w_fifo_full;
    assign w_push        = bus.cmd_valid && !w_fifo_full;

    always_comb begin
        w_push_cmd       = '0;
        w_push_cmd.write = bus.cmd_write;
        w_push_cmd.addr  = APB_ADDR_W'(bus.cmd_addr);
        w_push_cmd.wdata = APB_DATA_W'(bus.cmd_wdata);
    end

    apb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_pop_cmd),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_ACCESS && !bus.pready) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th stalled ACCESS cycle; the slave is abandoned after it.
    assign w_abort = (r_state == ST_ACCESS) && !bus.pready &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign w_abort = 1'b0;
`endif

    assign w_done = (r_state == ST_ACCESS) && (bus.pready || w_abort);
    assign w_pop  = !w_fifo_empty && ((r_state == ST_IDLE) || w_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_penable <= 1'b0;
                        if (w_fifo_empty) begin
                            r_psel  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
            // A pop always starts a new SETUP; psel stays high across back-to-back transfers.
            if (w_pop) begin
                r_state   <= ST_SETUP;
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_pwrite  <= w_pop_cmd.write;
                r_paddr   <= ADDR_W'(w_pop_cmd.addr);
                r_pwdata  <= w_pop_cmd.write ? DATA_W'(w_pop_cmd.wdata) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_err   <= w_abort ? 1'b1 : bus.pslverr;
                r_rsp_rdata <= (w_abort || r_pwrite) ? '0 : bus.prdata;
            end
        end
    end

    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
